decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and imm; legal values 32 or 64.
REQ-002 Parameter EN_M, default 1, 1 = decode RV32M ops, 0 = treat them as illegal.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  discard all buffered and incoming instructions this cycle.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both are high.
REQ-007 in_instr / in_pc  in  32 / XLEN  instruction word and its pc.
REQ-008 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-009 out_pc, out_imm  out  XLEN  pc passthrough and sign-extended immediate.
REQ-010 out_rs1, out_rs2, out_rd  out  5  register indices.
REQ-011 out_alu_ctr  out  5  ALU op; bit4 = M op with [2:0] = funct3.
REQ-012 out_alu_b_sel  out  1  0 = rs2, 1 = imm.
REQ-013 out_bxx  out  4  {is_branch, funct3}.
REQ-014 out_jal, out_jalr, out_reg_we, out_mem_we, out_illegal  out  1 each.
REQ-015 out_mem2reg  out  3  0 = alu, 1 = mem, 2 = pc+4, 3 = imm, 4 = pc+imm.
REQ-016 out_mem_opr / out_mem_opw  out  3 / 4  load funct3 / store byte mask (0001, 0011, 1111).

Function
REQ-017 Immediate formats: I, S, B, U, J per RV32I, sign-extended to XLEN; R-type imm = 0.
REQ-018 ALU codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111; bit4 = 0 for all of these.
REQ-019 ALU mapping: loads, stores, jalr and addi use add. beq/bne use sub. blt/bge use slt. bltu/bgeu use sltu.
REQ-020 out_reg_we = 1 only for R, OP-IMM, load, LUI, AUIPC, JAL and JALR, and only when rd != 0; it is 0 for branches and stores.
REQ-021 out_mem_we = 1 only for stores.
REQ-022 Illegal cases:
- instr[1:0] != 11
- unknown opcode
- R-type funct7 not in {0000000, 0100000 (add/sub, srl/sra only)}
- funct7 = 0000001 when EN_M = 0
- slli/srli/srai with a bad funct7
- invalid load/store/branch funct3
REQ-023 An illegal instruction SHALL pass through with out_illegal = 1 and reg_we, mem_we, jal, jalr and bxx[3] forced to 0.
REQ-024 Buffer: 2-entry FIFO of decoded bundles; decode occurs before the write into the buffer.
REQ-025 in_ready = (occupancy < 2); the ready path is registered and not combinational from out_ready.
REQ-026 Latency: an accepted instruction appears at out_valid on the next cycle at the earliest.
REQ-027 Throughput: 1 instruction per cycle when out_ready is held high.
REQ-028 Ordering is strictly FIFO, and out_* is stable while out_valid = 1 and out_ready = 0.
REQ-029 A simultaneous push and pop at occupancy 2 is impossible (in_ready = 0); at occupancy 1 it keeps occupancy at 1.
REQ-030 On flush, occupancy becomes 0 at the next edge, and the in_valid beat of the same cycle is dropped.
REQ-031 During a flush cycle, out_valid still reflects the current head.

Reset
REQ-032 While rst is high: occupancy = 0, out_valid = 0, in_ready = 1 after release, and all out_* payload = 0.
REQ-033 Reset mid-transfer SHALL discard all entries with no partial output.

Structure
REQ-034 Shared package rv_dec_pkg SHALL hold opcode constants, ALU codes, mem2reg codes and the decoded-bundle struct.
REQ-035 The combinational decoder SHALL be the sub-module rv_decode, instantiated once; decode_stage holds only the FIFO and handshake logic.

Verification
REQ-036 0x00500093 (addi x1,x0,5) -> imm 5, alu 00000, b_sel 1, rd 1, reg_we 1, mem2reg 0.
REQ-037 0x0020A423 (sw x2,8(x1)) -> imm 8, mem_we 1, reg_we 0, mem_opw 1111, alu add.
REQ-038 0xFE208EE3 (beq x1,x2,-4), XLEN = 32 -> imm 0xFFFFFFFC, bxx 1000, alu 01000, b_sel 0.
REQ-039 0x022081B3 (mul x3,x1,x2) -> alu 10000 when EN_M = 1; out_illegal = 1 and reg_we = 0 when EN_M = 0.
REQ-040 Backpressure: 3 back-to-back instructions with out_ready = 0 -> in_ready drops after 2 are accepted; after out_ready rises, all 3 emerge in order, one per cycle.
REQ-041 Flush with occupancy 2 and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and none of the 3 instructions is ever output.

Source files
------------

// File: rtl/rv_dec_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU and writeback codes, decoded bundle.
package rv_dec_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;

  localparam logic [2:0] M2R_ALU   = 3'd0;
  localparam logic [2:0] M2R_MEM   = 3'd1;
  localparam logic [2:0] M2R_PC4   = 3'd2;
  localparam logic [2:0] M2R_IMM   = 3'd3;
  localparam logic [2:0] M2R_PCIMM = 3'd4;

  // Control fields of one decoded instruction; pc and imm travel alongside (XLEN-sized).
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] alu_ctr;
    logic       alu_b_sel;
    logic [3:0] bxx;
    logic       jal;
    logic       jalr;
    logic       reg_we;
    logic       mem_we;
    logic       illegal;
    logic [2:0] mem2reg;
    logic [2:0] mem_opr;
    logic [3:0] mem_opw;
  } dec_t;

  // Byte-enable mask for sb / sh / sw.
  function automatic logic [3:0] store_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I(+M) decoder producing one control bundle and immediate.
module rv_decode
  import rv_dec_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec_c,
  output logic [XLEN-1:0]    imm_c
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm32;
  logic        bad;
  logic        writes;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Immediate is built at 32 bits and sign-extended to the datapath width.
  assign imm_c = XLEN'($signed(imm32));

  // Opcode decode, legality check, then suppression of side effects for illegal words.
  always_comb begin
    dec_c     = '0;
    imm32     = '0;
    bad       = 1'b0;
    writes    = 1'b0;
    dec_c.rs1 = instr[19:15];
    dec_c.rs2 = instr[24:20];
    dec_c.rd  = instr[11:7];
    case (opcode)
      OPC_LUI: begin
        imm32         = imm_u;
        writes        = 1'b1;
        dec_c.mem2reg = M2R_IMM;
      end
      OPC_AUIPC: begin
        imm32         = imm_u;
        writes        = 1'b1;
        dec_c.mem2reg = M2R_PCIMM;
      end
      OPC_JAL: begin
        imm32         = imm_j;
        writes        = 1'b1;
        dec_c.jal     = 1'b1;
        dec_c.mem2reg = M2R_PC4;
      end
      OPC_JALR: begin
        imm32           = imm_i;
        writes          = 1'b1;
        dec_c.jalr      = 1'b1;
        dec_c.alu_ctr   = ALU_ADD;
        dec_c.alu_b_sel = 1'b1;
        dec_c.mem2reg   = M2R_PC4;
      end
      OPC_BRANCH: begin
        imm32     = imm_b;
        dec_c.bxx = {1'b1, funct3};
        case (funct3[2:1])
          2'b00:   dec_c.alu_ctr = ALU_SUB;
          2'b10:   dec_c.alu_ctr = ALU_SLT;
          2'b11:   dec_c.alu_ctr = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm32           = imm_i;
        writes          = 1'b1;
        dec_c.alu_ctr   = ALU_ADD;
        dec_c.alu_b_sel = 1'b1;
        dec_c.mem2reg   = M2R_MEM;
        dec_c.mem_opr   = funct3;
        if (funct3[1:0] == 2'b11 || funct3 == 3'b110) bad = 1'b1;
      end
      OPC_STORE: begin
        imm32           = imm_s;
        dec_c.alu_ctr   = ALU_ADD;
        dec_c.alu_b_sel = 1'b1;
        dec_c.mem_we    = 1'b1;
        if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) dec_c.mem_opw = store_mask(funct3[1:0]);
        else bad = 1'b1;
      end
      OPC_OP_IMM: begin
        imm32           = imm_i;
        writes          = 1'b1;
        dec_c.alu_b_sel = 1'b1;
        dec_c.mem2reg   = M2R_ALU;
        case (funct3)
          3'b001: begin
            dec_c.alu_ctr = ALU_SLL;
            if (funct7 != 7'b0000000) bad = 1'b1;
          end
          3'b101: begin
            if (funct7 == 7'b0000000) dec_c.alu_ctr = ALU_SRL;
            else if (funct7 == 7'b0100000) dec_c.alu_ctr = ALU_SRA;
            else bad = 1'b1;
          end
          default: dec_c.alu_ctr = {2'b00, funct3};
        endcase
      end
      OPC_OP: begin
        writes        = 1'b1;
        dec_c.mem2reg = M2R_ALU;
        case (funct7)
          7'b0000000: dec_c.alu_ctr = {2'b00, funct3};
          7'b0100000: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) dec_c.alu_ctr = {2'b01, funct3};
            else bad = 1'b1;
          end
          7'b0000001: begin
            if (EN_M) dec_c.alu_ctr = {2'b10, funct3};
            else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    dec_c.reg_we = writes && (dec_c.rd != 5'd0) && !bad;
    if (bad) begin
      dec_c.illegal = 1'b1;
      dec_c.mem_we  = 1'b0;
      dec_c.jal     = 1'b0;
      dec_c.jalr    = 1'b0;
      dec_c.bxx[3]  = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decoder feeding a 2-entry registered FIFO with valid/ready handshakes.
module decode_stage
  import rv_dec_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_imm,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_alu_ctr,
  output logic               out_alu_b_sel,
  output logic [3:0]         out_bxx,
  output logic               out_jal,
  output logic               out_jalr,
  output logic               out_reg_we,
  output logic               out_mem_we,
  output logic               out_illegal,
  output logic [2:0]         out_mem2reg,
  output logic [2:0]         out_mem_opr,
  output logic [3:0]         out_mem_opw
);

  dec_t            dec_new;
  logic [XLEN-1:0] imm_new;

  // Head entry drives the outputs directly; tail holds the second buffered bundle.
  dec_t            head_dec, tail_dec, head_dec_nx, tail_dec_nx;
  logic [XLEN-1:0] head_pc, tail_pc, head_pc_nx, tail_pc_nx;
  logic [XLEN-1:0] head_imm, tail_imm, head_imm_nx, tail_imm_nx;
  logic [1:0]      count, count_nx;
  logic            push, pop;

  rv_decode #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_decode (
    .instr (in_instr),
    .dec_c (dec_new),
    .imm_c (imm_new)
  );

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // Next-state of the buffer: shift tail into head on pop, land new bundles in the free slot.
  always_comb begin
    head_dec_nx = head_dec;
    head_pc_nx  = head_pc;
    head_imm_nx = head_imm;
    tail_dec_nx = tail_dec;
    tail_pc_nx  = tail_pc;
    tail_imm_nx = tail_imm;
    count_nx    = count;
    if (flush) begin
      count_nx = 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_dec_nx = dec_new;
            head_pc_nx  = in_pc;
            head_imm_nx = imm_new;
            count_nx    = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_dec_nx = dec_new;
            head_pc_nx  = in_pc;
            head_imm_nx = imm_new;
          end else if (push) begin
            tail_dec_nx = dec_new;
            tail_pc_nx  = in_pc;
            tail_imm_nx = imm_new;
            count_nx    = 2'd2;
          end else if (pop) begin
            count_nx = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_dec_nx = tail_dec;
            head_pc_nx  = tail_pc;
            head_imm_nx = tail_imm;
            count_nx    = 2'd1;
          end
        end
        default: count_nx = 2'd0;
      endcase
    end
  end

  // Buffer registers; valid and ready are registered from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_dec  <= '0;
      head_pc   <= '0;
      head_imm  <= '0;
      tail_dec  <= '0;
      tail_pc   <= '0;
      tail_imm  <= '0;
      count     <= 2'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      head_dec  <= head_dec_nx;
      head_pc   <= head_pc_nx;
      head_imm  <= head_imm_nx;
      tail_dec  <= tail_dec_nx;
      tail_pc   <= tail_pc_nx;
      tail_imm  <= tail_imm_nx;
      count     <= count_nx;
      out_valid <= (count_nx != 2'd0);
      in_ready  <= (count_nx != 2'd2);
    end
  end

  assign out_pc        = head_pc;
  assign out_imm       = head_imm;
  assign out_rs1       = head_dec.rs1;
  assign out_rs2       = head_dec.rs2;
  assign out_rd        = head_dec.rd;
  assign out_alu_ctr   = head_dec.alu_ctr;
  assign out_alu_b_sel = head_dec.alu_b_sel;
  assign out_bxx       = head_dec.bxx;
  assign out_jal       = head_dec.jal;
  assign out_jalr      = head_dec.jalr;
  assign out_reg_we    = head_dec.reg_we;
  assign out_mem_we    = head_dec.mem_we;
  assign out_illegal   = head_dec.illegal;
  assign out_mem2reg   = head_dec.mem2reg;
  assign out_mem_opr   = head_dec.mem_opr;
  assign out_mem_opw   = head_dec.mem_opw;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, backpressure/flush/reset, randomized traffic vs a queue model.
module tb_decode_stage;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b01000, A_SLL = 5'b00001, A_SLT = 5'b00010;
  localparam logic [4:0] A_SLTU = 5'b00011, A_XOR = 5'b00100, A_SRL = 5'b00101, A_SRA = 5'b01101;
  localparam logic [4:0] A_OR = 5'b00110, A_AND = 5'b00111;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc;

  logic in_ready, out_valid, out_alu_b_sel, out_jal, out_jalr, out_reg_we, out_mem_we, out_illegal;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd, out_alu_ctr;
  logic [3:0] out_bxx, out_mem_opw;
  logic [2:0] out_mem2reg, out_mem_opr;

  logic nm_in_ready, nm_out_valid, nm_alu_b_sel, nm_jal, nm_jalr, nm_reg_we, nm_mem_we, nm_illegal;
  logic [XLEN-1:0] nm_pc, nm_imm;
  logic [4:0] nm_rs1, nm_rs2, nm_rd, nm_alu_ctr;
  logic [3:0] nm_bxx, nm_mem_opw;
  logic [2:0] nm_mem2reg, nm_mem_opr;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .EN_M(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_ctr(out_alu_ctr), .out_alu_b_sel(out_alu_b_sel), .out_bxx(out_bxx),
    .out_jal(out_jal), .out_jalr(out_jalr), .out_reg_we(out_reg_we), .out_mem_we(out_mem_we),
    .out_illegal(out_illegal), .out_mem2reg(out_mem2reg), .out_mem_opr(out_mem_opr),
    .out_mem_opw(out_mem_opw)
  );

  decode_stage #(.XLEN(XLEN), .EN_M(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_pc(nm_pc), .out_imm(nm_imm), .out_rs1(nm_rs1), .out_rs2(nm_rs2), .out_rd(nm_rd),
    .out_alu_ctr(nm_alu_ctr), .out_alu_b_sel(nm_alu_b_sel), .out_bxx(nm_bxx),
    .out_jal(nm_jal), .out_jalr(nm_jalr), .out_reg_we(nm_reg_we), .out_mem_we(nm_mem_we),
    .out_illegal(nm_illegal), .out_mem2reg(nm_mem2reg), .out_mem_opr(nm_mem_opr),
    .out_mem_opw(nm_mem_opw)
  );

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  alu, rs1, rs2, rd;
    logic        bsel, jal, jalr, we, mwe, ill;
    logic [3:0]  bxx, opw;
    logic [2:0]  m2r, opr;
    bit ck_alu, ck_bsel, ck_bxx, ck_m2r, ck_opr, ck_opw, ck_rs1, ck_rs2;
  } exp_t;

  exp_t q[$];
  logic [31:0] pop_log[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return alt ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // Reference decode from the ISA rules; immediates by plain arithmetic on the fields.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input bit en_m);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic wr;
    int ii, si, bi, ji;
    e = '{default: 0};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; wr = 1'b0;
    ii = int'($signed(w[31:20]));
    si = int'($signed(w[31:25])) * 32 + int'(w[11:7]);
    bi = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    ji = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.ck_m2r = 1'b1;
    case (op)
      7'b0110111: begin e.imm = w & 32'hFFFFF000; e.m2r = 3'd3; wr = 1'b1; end
      7'b0010111: begin e.imm = w & 32'hFFFFF000; e.m2r = 3'd4; wr = 1'b1; end
      7'b1101111: begin e.imm = 32'(ji); e.jal = 1'b1; e.m2r = 3'd2; wr = 1'b1; end
      7'b1100111: begin
        e.imm = 32'(ii); e.jalr = 1'b1; e.m2r = 3'd2; e.alu = A_ADD; e.bsel = 1'b1; wr = 1'b1;
        e.ck_alu = 1'b1; e.ck_bsel = 1'b1; e.ck_rs1 = 1'b1;
      end
      7'b1100011: begin
        e.imm = 32'(bi); e.bxx = {1'b1, f3}; e.bsel = 1'b0; e.ck_m2r = 1'b0;
        e.ck_bxx = 1'b1; e.ck_alu = 1'b1; e.ck_bsel = 1'b1; e.ck_rs1 = 1'b1; e.ck_rs2 = 1'b1;
        if (f3 == 3'd0 || f3 == 3'd1) e.alu = A_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) e.alu = A_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) e.alu = A_SLTU;
        else e.ill = 1'b1;
      end
      7'b0000011: begin
        e.imm = 32'(ii); e.alu = A_ADD; e.bsel = 1'b1; e.m2r = 3'd1; e.opr = f3; wr = 1'b1;
        e.ck_alu = 1'b1; e.ck_bsel = 1'b1; e.ck_opr = 1'b1; e.ck_rs1 = 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e.ill = 1'b1;
      end
      7'b0100011: begin
        e.imm = 32'(si); e.mwe = 1'b1; e.alu = A_ADD; e.bsel = 1'b1; e.ck_m2r = 1'b0;
        e.ck_alu = 1'b1; e.ck_bsel = 1'b1; e.ck_opw = 1'b1; e.ck_rs1 = 1'b1; e.ck_rs2 = 1'b1;
        if (f3 == 3'd0) e.opw = 4'b0001;
        else if (f3 == 3'd1) e.opw = 4'b0011;
        else if (f3 == 3'd2) e.opw = 4'b1111;
        else e.ill = 1'b1;
      end
      7'b0010011: begin
        e.imm = 32'(ii); e.bsel = 1'b1; e.m2r = 3'd0; wr = 1'b1;
        e.ck_alu = 1'b1; e.ck_bsel = 1'b1; e.ck_rs1 = 1'b1;
        e.alu = base_alu(f3, f3 == 3'd5 && f7 == 7'h20);
        if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
      end
      7'b0110011: begin
        e.imm = 32'd0; e.bsel = 1'b0; e.m2r = 3'd0; wr = 1'b1;
        e.ck_alu = 1'b1; e.ck_bsel = 1'b1; e.ck_rs1 = 1'b1; e.ck_rs2 = 1'b1;
        if (f7 == 7'h01) begin
          if (en_m) e.alu = {2'b10, f3}; else e.ill = 1'b1;
        end else if (f7 == 7'h00) begin
          e.alu = base_alu(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          e.alu = base_alu(f3, 1'b1);
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    if (w[1:0] != 2'b11) e.ill = 1'b1;
    e.we = wr && (w[11:7] != 5'd0) && !e.ill;
    if (e.ill) begin e.mwe = 1'b0; e.jal = 1'b0; e.jalr = 1'b0; e.bxx[3] = 1'b0; end
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w;
    int k;
    w = $urandom();
    k = $urandom_range(0, 10);
    case (k)
      0: w[6:0] = 7'b0110111;
      1: w[6:0] = 7'b0010111;
      2: w[6:0] = 7'b1101111;
      3: w[6:0] = 7'b1100111;
      4: w[6:0] = 7'b1100011;
      5: w[6:0] = 7'b0000011;
      6: w[6:0] = 7'b0100011;
      7, 8: w[6:0] = 7'b0010011;
      9: w[6:0] = 7'b0110011;
      default: ;
    endcase
    if (k >= 7 && k <= 9) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  // One cycle at the falling edge: check outputs against the model, drive inputs, advance model.
  task automatic step(input logic iv, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    exp_t e;
    int n;
    in_valid = iv; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    n = q.size();
    check("out_valid", out_valid, n != 0);
    check("in_ready", in_ready, n < 2);
    if (n != 0) begin
      e = q[0];
      check("pc", out_pc, e.pc);
      check("rd", out_rd, e.rd);
      check("illegal", out_illegal, e.ill);
      check("reg_we", out_reg_we, e.we);
      check("mem_we", out_mem_we, e.mwe);
      check("jal", out_jal, e.jal);
      check("jalr", out_jalr, e.jalr);
      check("is_branch", out_bxx[3], e.bxx[3]);
      if (!e.ill) begin
        check("imm", out_imm, e.imm);
        if (e.ck_m2r) check("mem2reg", out_mem2reg, e.m2r);
        if (e.ck_alu) check("alu_ctr", out_alu_ctr, e.alu);
        if (e.ck_bsel) check("alu_b_sel", out_alu_b_sel, e.bsel);
        if (e.ck_bxx) check("bxx", out_bxx, e.bxx);
        if (e.ck_opr) check("mem_opr", out_mem_opr, e.opr);
        if (e.ck_opw) check("mem_opw", out_mem_opw, e.opw);
        if (e.ck_rs1) check("rs1", out_rs1, e.rs1);
        if (e.ck_rs2) check("rs2", out_rs2, e.rs2);
      end
      if (ordy) begin
        pop_log.push_back(out_pc);
        void'(q.pop_front());
      end
    end
    if (fl) q.delete();
    else if (iv && n < 2) q.push_back(model(w, pc, 1'b1));
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_alu", out_alu_ctr, 5'd0);
    check("rst_illegal", out_illegal, 1'b0);
    check("rst_opw", out_mem_opw, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);

    // addi x1,x0,5
    step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    check("addi_valid", out_valid, 1'b1);
    check("addi_imm", out_imm, 32'd5);
    check("addi_alu", out_alu_ctr, 5'b00000);
    check("addi_bsel", out_alu_b_sel, 1'b1);
    check("addi_rd", out_rd, 5'd1);
    check("addi_we", out_reg_we, 1'b1);
    check("addi_m2r", out_mem2reg, 3'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // sw x2,8(x1)
    step(1'b1, 32'h0020A423, 32'h104, 1'b0, 1'b0);
    check("sw_imm", out_imm, 32'd8);
    check("sw_mem_we", out_mem_we, 1'b1);
    check("sw_reg_we", out_reg_we, 1'b0);
    check("sw_opw", out_mem_opw, 4'b1111);
    check("sw_alu", out_alu_ctr, 5'b00000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // beq x1,x2,-4
    step(1'b1, 32'hFE208EE3, 32'h108, 1'b0, 1'b0);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_bxx", out_bxx, 4'b1000);
    check("beq_alu", out_alu_ctr, 5'b01000);
    check("beq_bsel", out_alu_b_sel, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // mul x3,x1,x2 with and without M support
    step(1'b1, 32'h022081B3, 32'h10C, 1'b0, 1'b0);
    check("mul_alu", out_alu_ctr, 5'b10000);
    check("mul_we", out_reg_we, 1'b1);
    check("mul_ill", out_illegal, 1'b0);
    check("nom_valid", nm_out_valid, 1'b1);
    check("nom_ill", nm_illegal, 1'b1);
    check("nom_we", nm_reg_we, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: third beat stalls until the consumer drains
    pop_log.delete();
    step(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check("bp_first", pop_log[0], 32'h200);
      check("bp_second", pop_log[1], 32'h204);
      check("bp_third", pop_log[2], 32'h208);
    end

    // Flush with a full buffer and an incoming beat
    pop_log.delete();
    step(1'b1, 32'h00400293, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00500313, 32'h304, 1'b0, 1'b0);
    check("fl_head_pc", out_pc, 32'h300);
    step(1'b1, 32'h00600393, 32'h308, 1'b0, 1'b1);
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("fl_none_out", pop_log.size(), 0);

    // Reset in the middle of buffered traffic
    step(1'b1, 32'h00700413, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00800493, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_pc", out_pc, 32'd0);
    check("mr_we", out_reg_we, 1'b0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mr_in_ready", in_ready, 1'b1);

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, gen(), $urandom() & 32'hFFFFFFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    n = 0;
    while (q.size() != 0 && n < 8) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    check("drain_empty", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
